// File: rtl/fifo_push_arb_pkg.sv
// fifo_push_arb_pkg: default parameters and counter width for the FIFO push arbiter
package fifo_push_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 32;
  localparam int CNT_W = 32;
endpackage

// File: rtl/fifo_push_arb_rr_arb_core.sv
// rr_arb_core: combinational round-robin search starting at ptr, one-hot grant
module rr_arb_core #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt
);
  localparam int PW = $clog2(N);
  logic [PW:0] sum;
  logic [PW-1:0] idx;
  logic found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin arbiter sharing one FIFO write port, with occupancy tracking
// FIFO_PUSH_ARB_STATS_EN builds saturating grant/stall counters; otherwise they read 0.
module fifo_push_arb
  import fifo_push_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  gnt,
  input  logic                                fifo_rden,
  output logic                                fifo_wren,
  output logic [DATA_WIDTH-1:0]               fifo_wrdata,
  output logic [$clog2(DEPTH+1)-1:0]          occupancy,
  output logic [CNT_W-1:0]                    grant_cnt,
  output logic [CNT_W-1:0]                    stall_cnt
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int OW = $clog2(DEPTH+1);
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic space;
  logic any_gnt;
  logic rd_eff;
  // a read in the same cycle frees the slot a full FIFO needs
  assign space = (occupancy < OW'(DEPTH)) || fifo_rden;
  assign any_gnt = |gnt;
  assign rd_eff = fifo_rden && (occupancy != '0);
  rr_arb_core #(.N(NUM_REQ)) u_core (
    .req(req),
    .ptr(ptr),
    .en (rst_n && space),
    .gnt(gnt)
  );
  always_comb begin
    gnt_idx = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PW'(i);
        gnt_data = req_data[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      fifo_wren <= 1'b0;
      fifo_wrdata <= '0;
      occupancy <= '0;
    end else begin
      fifo_wren <= any_gnt;
      if (any_gnt) begin
        fifo_wrdata <= gnt_data;
        ptr <= (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      occupancy <= occupancy + OW'(any_gnt) - OW'(rd_eff);
    end
  end
`ifdef FIFO_PUSH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      grant_cnt <= (any_gnt && !(&grant_cnt)) ? grant_cnt + 1'b1 : grant_cnt;
      stall_cnt <= ((|req) && !any_gnt && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: scoreboard bench for fifo_push_arb with a behavioural downstream FIFO
module tb_fifo_push_arb;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int DEPTH = 32;
`ifdef FIFO_PUSH_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic tb_clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0] gnt;
  logic fifo_rden;
  logic fifo_wren;
  logic [DW-1:0] fifo_wrdata;
  logic [5:0] occupancy;
  logic [31:0] grant_cnt;
  logic [31:0] stall_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr;
  int m_occ;
  logic [31:0] m_gcnt;
  logic [31:0] m_scnt;
  logic [DW-1:0] m_last;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] go_q[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rd_q[$];
  int ovf = 0;
  logic [N-1:0] obs_gnt;

  fifo_push_arb dut (
    .clk(tb_clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_rden(fifo_rden), .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .occupancy(occupancy), .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
  );

  always #5 tb_clk = ~tb_clk;

  // downstream FIFO shares rst_n and flags any write into a full FIFO
  always @(posedge tb_clk or negedge rst_n) begin
    if (!rst_n) fq.delete();
    else begin
      if (fifo_rden && fq.size() > 0) rd_q.push_back(fq.pop_front());
      if (fifo_wren) begin
        if (fq.size() >= DEPTH) ovf++;
        fq.push_back(fifo_wrdata);
      end
    end
  end

  task automatic clear_model();
    m_ptr = 0; m_occ = 0; m_gcnt = 0; m_scnt = 0; m_last = '0;
    sb_q.delete(); go_q.delete(); rd_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; fifo_rden = 1'b0;
    clear_model();
    repeat (2) @(negedge tb_clk);
    rst_n = 1'b1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i] = DW'($urandom_range(0, 255));
  endtask

  // one cycle: inputs already driven at the negedge; returns at the next negedge
  task automatic tick();
    logic [N-1:0] eg;
    logic [DW-1:0] exp_d;
    int k;
    bit rd;
    bit wr;
    #1;
    eg = '0; k = -1;
    if (m_occ < DEPTH || fifo_rden)
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (k < 0 && req[j]) k = j;
      end
    if (k >= 0) eg[k] = 1'b1;
    obs_gnt = gnt;
    n_cmp++;
    if (gnt !== eg) begin n_bad++; $display("FAIL gnt: got %b want %b", gnt, eg); end
    rd = fifo_rden && m_occ > 0;
    wr = (k >= 0);
    if (wr) begin
      sb_q.push_back(req_data[k]); go_q.push_back(req_data[k]);
      m_ptr = (k + 1) % N; m_gcnt++;
    end else if (req != 0) m_scnt++;
    m_occ = m_occ + (wr ? 1 : 0) - (rd ? 1 : 0);
    @(posedge tb_clk); #1;
    if (wr) begin exp_d = sb_q.pop_front(); m_last = exp_d; end
    n_cmp++;
    if (fifo_wren !== wr || fifo_wrdata !== m_last) begin
      n_bad++; $display("FAIL write: got wren=%b data=%h want wren=%b data=%h", fifo_wren, fifo_wrdata, wr, m_last);
    end
    n_cmp++;
    if (occupancy !== 6'(m_occ)) begin n_bad++; $display("FAIL occupancy: got %0d want %0d", occupancy, m_occ); end
    n_cmp++;
    if (grant_cnt !== (STATS ? m_gcnt : 32'd0) || stall_cnt !== (STATS ? m_scnt : 32'd0)) begin
      n_bad++; $display("FAIL counters: got g=%0d s=%0d want g=%0d s=%0d", grant_cnt, stall_cnt,
                        STATS ? m_gcnt : 32'd0, STATS ? m_scnt : 32'd0);
    end
    @(negedge tb_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; fifo_rden = 1'b0; randomize_data();
    #1;
    n_cmp++;
    if (gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    @(posedge tb_clk); #1;
    n_cmp++;
    if ({fifo_wren, fifo_wrdata, occupancy, grant_cnt, stall_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_outs: got wren=%b data=%h occ=%0d g=%0d s=%0d want all 0",
                        fifo_wren, fifo_wrdata, occupancy, grant_cnt, stall_cnt);
    end
    @(negedge tb_clk);
    do_reset();
  endtask

  task automatic test_rotation();
    logic [N-1:0] e;
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      randomize_data();
      tick();
      e = 4'b0001 << (i % N);
      n_cmp++;
      if (obs_gnt !== e) begin n_bad++; $display("FAIL rotation[%0d]: got %b want %b", i, obs_gnt, e); end
    end
    req = '0;
  endtask

  task automatic test_fill();
    int ng;
    do_reset();
    ng = 0; req = 4'hF;
    repeat (40) begin
      randomize_data();
      tick();
      if (obs_gnt != 0) ng++;
    end
    n_cmp++;
    if (ng !== DEPTH) begin n_bad++; $display("FAIL fill_grants: got %0d want %0d", ng, DEPTH); end
    n_cmp++;
    if (obs_gnt !== 4'b0 || occupancy !== 6'd32) begin
      n_bad++; $display("FAIL fill_full: got gnt=%b occ=%0d want gnt=0000 occ=32", obs_gnt, occupancy);
    end
    n_cmp++;
    if (stall_cnt !== (STATS ? 32'd8 : 32'd0)) begin
      n_bad++; $display("FAIL fill_stall: got %0d want %0d", stall_cnt, STATS ? 8 : 0);
    end
  endtask

  task automatic test_full_rden();
    logic [DW-1:0] first;
    req = 4'b0001; fifo_rden = 1'b1; randomize_data();
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0001 || occupancy !== 6'd32) begin
      n_bad++; $display("FAIL full_rden: got gnt=%b occ=%0d want gnt=0001 occ=32", obs_gnt, occupancy);
    end
    req = '0; fifo_rden = 1'b0;
    tick();
    first = go_q.pop_front();
    n_cmp++;
    if (rd_q.size() != 1 || rd_q[0] !== first) begin
      n_bad++; $display("FAIL full_rd_data: got n=%0d want n=1 data=%h", rd_q.size(), first);
    end
    n_cmp++;
    if (ovf !== 0) begin n_bad++; $display("FAIL overflow: got %0d want 0", ovf); end
  endtask

  task automatic test_ptr();
    do_reset();
    randomize_data();
    req = 4'b1000; tick();
    n_cmp++;
    if (obs_gnt !== 4'b1000) begin n_bad++; $display("FAIL ptr_a: got %b want 1000", obs_gnt); end
    req = 4'b0100; tick();
    n_cmp++;
    if (obs_gnt !== 4'b0100) begin n_bad++; $display("FAIL ptr_b: got %b want 0100", obs_gnt); end
    req = 4'b1111; tick();
    n_cmp++;
    if (obs_gnt !== 4'b1000) begin n_bad++; $display("FAIL ptr_c: got %b want 1000", obs_gnt); end
    req = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'hF;
    repeat (3) begin randomize_data(); tick(); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, fifo_wren, fifo_wrdata, occupancy} !== '0) begin
      n_bad++; $display("FAIL mid_reset: got gnt=%b wren=%b data=%h occ=%0d want all 0", gnt, fifo_wren, fifo_wrdata, occupancy);
    end
    clear_model();
    @(negedge tb_clk);
    rst_n = 1'b1;
    req = 4'b0110; tick();
    n_cmp++;
    if (obs_gnt !== 4'b0010) begin n_bad++; $display("FAIL post_reset: got %b want 0010", obs_gnt); end
    req = '0;
  endtask

  task automatic test_drain();
    do_reset();
    fifo_rden = 1'b1; tick();
    n_cmp++;
    if (occupancy !== 6'd0) begin n_bad++; $display("FAIL empty_rden: got %0d want 0", occupancy); end
    fifo_rden = 1'b0; req = 4'hF;
    repeat (DEPTH) begin randomize_data(); tick(); end
    req = '0; tick();
    fifo_rden = 1'b1;
    repeat (DEPTH) tick();
    fifo_rden = 1'b0; tick();
    n_cmp++;
    if (rd_q.size() != DEPTH || go_q.size() != DEPTH) begin
      n_bad++; $display("FAIL drain_count: got %0d want %0d", rd_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (rd_q[i] !== go_q[i]) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_q[i], go_q[i]); end
      end
    end
    n_cmp++;
    if (occupancy !== 6'd0 || ovf !== 0) begin
      n_bad++; $display("FAIL drain_end: got occ=%0d ovf=%0d want 0 0", occupancy, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_fill();
    test_full_rden();
    test_ptr();
    test_mid_reset();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one simple_fifo write port (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, write data width.
REQ-003 Parameter DEPTH, default 32, capacity of the downstream FIFO in entries.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester push request, level.
REQ-007 req_data  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-008 gnt  output  NUM_REQ  one-hot grant, combinational; requester data is consumed in that cycle.
REQ-009 fifo_rden  input  1  copy of the FIFO read enable, for occupancy tracking.
REQ-010 fifo_wren  output  1  registered FIFO write enable.
REQ-011 fifo_wrdata  output  DATA_WIDTH  registered FIFO write data.
REQ-012 occupancy  output  $clog2(DEPTH+1)  tracked FIFO entry count.
REQ-013 grant_cnt  output  32  total grants issued (REQ-028).
REQ-014 stall_cnt  output  32  cycles with any req but no gnt (REQ-028).

Function
REQ-015 Requester holds req and req_data stable until it sees gnt; gnt is high for exactly one cycle per accepted push.
REQ-016 At most one gnt bit is high per cycle; gnt is zero when req is zero.
REQ-017 Grant is permitted only when occupancy < DEPTH, or occupancy == DEPTH and fifo_rden is high this cycle.
REQ-018 Round-robin: the search starts at index ptr; the first requesting index at or after ptr, wrapping modulo NUM_REQ, wins.
REQ-019 On grant to index k, ptr becomes (k+1) mod NUM_REQ next cycle; with no grant, ptr is unchanged.
REQ-020 On grant to k, fifo_wren=1 and fifo_wrdata=req_data[k] next cycle; otherwise fifo_wren=0 and fifo_wrdata holds its last value. Latency is 1 cycle from gnt to fifo_wren.
REQ-021 occupancy increments on a grant and decrements on fifo_rden when occupancy>0; grant plus rden in the same cycle leaves it unchanged.
REQ-022 fifo_rden with occupancy==0 is ignored (no wrap below 0).
REQ-023 occupancy never exceeds DEPTH, so the FIFO overflow_err is never provoked by this block.
REQ-024 Continuous requests from all requesters with space available give one grant per cycle in strict rotation 0,1,..,NUM_REQ-1,0...

Reset
REQ-025 While rst_n is low: gnt=0, fifo_wren=0, fifo_wrdata=0, occupancy=0, ptr=0, grant_cnt=0, stall_cnt=0.
REQ-026 Reset asserted mid-transfer discards any pending write; the FIFO is reset with the same rst_n.
REQ-027 In the first cycle after release, requester 0 has highest priority.

Configuration
REQ-028 Macro FIFO_PUSH_ARB_STATS_EN: when defined, grant_cnt increments on every grant and stall_cnt increments on every cycle with req!=0 and gnt==0. Both counters saturate at all-ones.
REQ-029 When FIFO_PUSH_ARB_STATS_EN is undefined, grant_cnt and stall_cnt are tied to 0 and no counter flops are built; the ports remain present.

Structure
REQ-030 Package fifo_push_arb_pkg holds the default parameter constants and the counter width constant (32).
REQ-031 One sub-module, rr_arb_core, contains the combinational round-robin search given req, ptr and enable, and outputs one-hot gnt.

Verification
REQ-032 Reset, then req=4'b1111 held, fifo_rden=0 -> gnt sequence 0001,0010,0100,1000,0001...; fifo_wren one cycle after each gnt with matching data.
REQ-033 Requesters fill DEPTH=32 entries with no reads -> exactly 32 grants, then gnt=0; occupancy=32; the FIFO shows no overflow_err; stall_cnt counts up with STATS_EN.
REQ-034 occupancy==32, req=0001 and fifo_rden=1 in the same cycle -> grant issued and occupancy stays 32.
REQ-035 Only req[2] held after a grant to index 3 (ptr=0) -> gnt[2] next cycle; ptr becomes 3.
REQ-036 Reset asserted during streaming writes -> all outputs are 0 immediately; after release the first grant goes to the lowest requesting index.
REQ-037 fifo_rden pulsed with occupancy 0 -> occupancy stays 0; a full fill/drain with the simple FIFO returns the data in grant order.
